// File: rtl/johnson_phase_monitor.sv
// Decodes a Johnson counter bus into one-hot/binary phase and checks code legality, step order and revolutions.
// Optional feature: define JMON_BIDIR_EN to accept reverse steps (and count reverse revolutions).
module johnson_phase_monitor #(
  parameter int WIDTH = 4,
  parameter int REV_W = 8,
  parameter int IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic [WIDTH-1:0]     cnt_in,
  input  logic                 cnt_valid,
  input  logic                 clr_err,
  output logic [2*WIDTH-1:0]   phase_onehot,
  output logic [IDX_W-1:0]     phase_idx,
  output logic                 phase_valid,
  output logic                 illegal_code,
  output logic                 seq_err,
  output logic                 rev_pulse,
  output logic [REV_W-1:0]     rev_count
);

  localparam int NPH = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ALL1 = '1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NPH - 1);

  typedef enum logic [1:0] {SYNC, LOCKED, FAULT} state_t;

  state_t             state_q, state_d;
  logic [NPH-1:0]     phase_onehot_q, phase_onehot_d;
  logic [IDX_W-1:0]   phase_idx_q, phase_idx_d;
  logic               phase_valid_q, phase_valid_d;
  logic               illegal_code_q, illegal_code_d;
  logic               seq_err_q, seq_err_d;
  logic               rev_pulse_q, rev_pulse_d;
  logic [REV_W-1:0]   rev_count_q, rev_count_d;

  // Canonical code per phase: ones fill in from the LSB, then drain out from the LSB.
  logic [WIDTH-1:0] canon [NPH];
  generate
    for (genvar gi = 0; gi < NPH; gi++) begin : g_canon
      if (gi <= WIDTH) begin : g_fill
        assign canon[gi] = ~(ALL1 << gi);
      end else begin : g_drain
        assign canon[gi] = ALL1 << (gi - WIDTH);
      end
    end
  endgenerate

  logic [IDX_W:0]   pop, k_full;
  logic [IDX_W-1:0] k;
  logic             legal;
  logic [NPH-1:0]   onehot_k;
  logic [IDX_W-1:0] idx_inc;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + (IDX_W+1)'(cnt_in[i]);
    k_full = cnt_in[WIDTH-1] ? (IDX_W+1)'(NPH) - pop : pop;
    k      = k_full[IDX_W-1:0];
    legal  = 1'b0;
    for (int i = 0; i < NPH; i++) begin
      if (k_full == (IDX_W+1)'(i) && cnt_in == canon[i]) legal = 1'b1;
    end
    onehot_k = {{(NPH-1){1'b0}}, 1'b1} << k;
    idx_inc  = (phase_idx_q == LAST) ? '0 : phase_idx_q + 1'b1;
  end

`ifdef JMON_BIDIR_EN
  logic [IDX_W-1:0] idx_dec;
  assign idx_dec = (phase_idx_q == '0) ? LAST : phase_idx_q - 1'b1;
`endif

  logic go_fault;

  always_comb begin
    state_d        = state_q;
    phase_onehot_d = phase_onehot_q;
    phase_idx_d    = phase_idx_q;
    phase_valid_d  = phase_valid_q;
    illegal_code_d = 1'b0;
    seq_err_d      = seq_err_q;
    rev_pulse_d    = 1'b0;
    rev_count_d    = rev_count_q;
    go_fault       = 1'b0;

    if (clr_err) begin
      // Resync: the concurrent sample is discarded, revolution count is kept.
      state_d        = SYNC;
      seq_err_d      = 1'b0;
      phase_valid_d  = 1'b0;
      phase_onehot_d = '0;
    end else if (cnt_valid) begin
      illegal_code_d = ~legal;
      case (state_q)
        SYNC: begin
          if (legal) begin
            state_d        = LOCKED;
            phase_idx_d    = k;
            phase_onehot_d = onehot_k;
            phase_valid_d  = 1'b1;
          end else begin
            go_fault = 1'b1;
          end
        end
        LOCKED: begin
          if (legal && k == phase_idx_q) begin
            phase_valid_d = 1'b1;
          end else if (legal && k == idx_inc) begin
            phase_idx_d    = k;
            phase_onehot_d = onehot_k;
            phase_valid_d  = 1'b1;
            if (phase_idx_q == LAST) begin
              rev_pulse_d = 1'b1;
              rev_count_d = rev_count_q + 1'b1;
            end
`ifdef JMON_BIDIR_EN
          end else if (legal && k == idx_dec) begin
            phase_idx_d    = k;
            phase_onehot_d = onehot_k;
            phase_valid_d  = 1'b1;
            if (phase_idx_q == '0) begin
              rev_pulse_d = 1'b1;
              rev_count_d = rev_count_q - 1'b1;
            end
`endif
          end else begin
            go_fault = 1'b1;
          end
        end
        FAULT:   seq_err_d = 1'b1;
        default: state_d = SYNC;
      endcase
    end

    if (go_fault) begin
      state_d        = FAULT;
      phase_valid_d  = 1'b0;
      phase_onehot_d = '0;
      seq_err_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      state_q        <= SYNC;
      phase_onehot_q <= '0;
      phase_idx_q    <= '0;
      phase_valid_q  <= 1'b0;
      illegal_code_q <= 1'b0;
      seq_err_q      <= 1'b0;
      rev_pulse_q    <= 1'b0;
      rev_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      phase_onehot_q <= phase_onehot_d;
      phase_idx_q    <= phase_idx_d;
      phase_valid_q  <= phase_valid_d;
      illegal_code_q <= illegal_code_d;
      seq_err_q      <= seq_err_d;
      rev_pulse_q    <= rev_pulse_d;
      rev_count_q    <= rev_count_d;
    end
  end

  assign phase_onehot = phase_onehot_q;
  assign phase_idx    = phase_idx_q;
  assign phase_valid  = phase_valid_q;
  assign illegal_code = illegal_code_q;
  assign seq_err      = seq_err_q;
  assign rev_pulse    = rev_pulse_q;
  assign rev_count    = rev_count_q;

endmodule
